wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file: consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it into a 16 × 32-bit register file. It also provides two read ports to the ID stage and exports the committed write for EX-stage forwarding. Register 0 reads as zero, the link register receives PC+4 on calls, and the stack pointer has a non-zero reset value.

## Interface

Parameters:
- NUM_REGS, 16, number of architectural registers; address width is log2(NUM_REGS) = 4
- LINK_REG, 15, destination forced for call writeback
- SP_REG, 14, stack pointer index
- SP_INIT, 32'h0000_FFFC, stack pointer reset value

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_out  in  32  load data from MEM/WB
- alu_out  in  32  ALU result from MEM/WB
- pc_plus4  in  32  return address from MEM/WB
- reg_dst  in  4  destination register from MEM/WB
- reg_wr  in  1  register write enable from MEM/WB
- wb_sel  in  1  1 = mem_out, 0 = alu_out
- call  in  1  call instruction in WB
- rd_addr_a  in  4  read port A address
- rd_addr_b  in  4  read port B address
- rd_data_a  out  32  read port A data
- rd_data_b  out  32  read port B data
- wb_en  out  1  effective write enable this cycle, for forwarding
- wb_dst  out  4  effective destination this cycle
- wb_data  out  32  effective write data this cycle

## Operation

- Writeback resolution, combinational:
  - call = 1: wb_dst = LINK_REG, wb_data = pc_plus4, and the write is enabled regardless of reg_wr, reg_dst and wb_sel.
  - Otherwise: wb_dst = reg_dst, wb_data = wb_sel ? mem_out : alu_out, and the write enable is reg_wr.
  - wb_en is the resolved enable AND (wb_dst != 0).
- Commit: on the rising clk edge with wb_en = 1, regs[wb_dst] ← wb_data. Register 0 is never written and has no storage.
- Reads are combinational: rd_data_x = regs[rd_addr_x]. Address 0 always reads 0.
- Write-through bypass: if wb_en = 1 and rd_addr_x == wb_dst, rd_data_x = wb_data in the same cycle. ID therefore sees a value written in that cycle.
- Stall and flush handling: none inside this block. MEM/WB holding its outputs re-writes the same value, which is idempotent. MEM/WB flush presents reg_wr = 0 and call = 0, so no write occurs.

## Timing

- Write latency: data is visible at the read ports in the cycle it is presented (bypass). It is held in storage from the next edge onward.
- Read latency: 0 cycles, purely combinational.
- Reset (async, rst_n low): all registers cleared to 0 immediately, except regs[SP_REG] = SP_INIT.
  - During reset, rd_data_x reflects the reset contents (0, or SP_INIT for SP_REG).
  - wb_en, wb_dst and wb_data follow their inputs combinationally.
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Reset deasserts asynchronously. The first write is taken at the first rising edge with rst_n high.
- Both read ports may address the same register, including the write target. Both return the bypassed value.
- reg_wr = 1 with reg_dst = 0: no write, wb_en = 0, and nothing is forwarded.
- call = 1 with reg_wr = 0: the LINK_REG write still occurs.

## Structure

- Shared package cpu_pkg provides:
  - REG_ADDR_W = 4, DATA_W = 32
  - LINK_REG and SP_REG index constants
  - SP_INIT reset constant
- The pipeline registers and the hazard unit reuse these package constants.
- One natural sub-module, wb_select: the combinational writeback mux and enable resolution that produces wb_en, wb_dst and wb_data.
- The storage array, reset and bypass stay in wb_regfile.

## Test plan

- Reset: assert rst_n = 0 mid-run, then read all 16 addresses. Expect 0 everywhere except r14 = 32'h0000_FFFC.
- ALU and memory writeback:
  - reg_wr = 1, wb_sel = 0, reg_dst = 3, alu_out = 32'hDEAD_BEEF. Next cycle rd_addr_a = 3 reads 32'hDEAD_BEEF.
  - Repeat with wb_sel = 1, mem_out = 32'h1234_5678. Expect 32'h1234_5678.
- Call: call = 1, reg_wr = 0, reg_dst = 5, pc_plus4 = 32'h0000_0104. Expect r15 = 32'h0000_0104, r5 unchanged, wb_dst = 15.
- Bypass: write r7 = 32'hA5A5_A5A5 with rd_addr_a = rd_addr_b = 7 in the same cycle. Both read ports show 32'hA5A5_A5A5 before the edge.
- Register zero: reg_wr = 1, reg_dst = 0, alu_out = 32'hFFFF_FFFF. Expect wb_en = 0 and r0 reads 0 in the same and following cycles.
- Flush and stall: hold identical inputs for 3 cycles (stall). Expect a single stable value. Then reg_wr = 0, call = 0 (flush). Expect no register change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Core-wide constants shared by the pipeline registers, hazard unit and writeback.
// Register-file geometry, special register indices and the stack pointer reset value.
package cpu_pkg;

    localparam int          REG_ADDR_W   = 4;
    localparam int          DATA_W       = 32;
    localparam int          NUM_REGS_DEF = 16;
    localparam int          LINK_REG_IDX = 15;
    localparam int          SP_REG_IDX   = 14;
    localparam logic [31:0] SP_INIT_VAL  = 32'h0000_FFFC;

endpackage

// File: rtl/wb_select.sv
// Writeback resolution: picks the commit value/destination, forces link-register writes on calls.
// Purely combinational (0 cycles); no flow control, the result is consumed every cycle.
module wb_select
    import cpu_pkg::*;
#(
    parameter int LINK_REG = LINK_REG_IDX
) (
    input  logic                  call_i,
    input  logic                  reg_wr_i,
    input  logic                  wb_sel_i,
    input  logic [REG_ADDR_W-1:0] reg_dst_i,
    input  logic [DATA_W-1:0]     mem_out_i,
    input  logic [DATA_W-1:0]     alu_out_i,
    input  logic [DATA_W-1:0]     pc_plus4_i,
    output logic                  wb_en_o,
    output logic [REG_ADDR_W-1:0] wb_dst_o,
    output logic [DATA_W-1:0]     wb_data_o
);

    logic                  en_raw;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;

    always_comb begin
        en_raw = reg_wr_i;
        dst    = reg_dst_i;
        data   = wb_sel_i ? mem_out_i : alu_out_i;
        // A call overrides whatever the instruction encoded for its destination.
        if (call_i) begin
            en_raw = 1'b1;
            dst    = REG_ADDR_W'(LINK_REG);
            data   = pc_plus4_i;
        end
    end

    assign wb_en_o   = en_raw && (dst != '0);
    assign wb_dst_o  = dst;
    assign wb_data_o = data;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 2-read/1-write register file; r0 hardwired to zero, SP resets to SP_INIT.
// Reads are combinational with same-cycle write-through; writes commit on the next edge; no backpressure.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int          NUM_REGS = NUM_REGS_DEF,
    parameter int          LINK_REG = LINK_REG_IDX,
    parameter int          SP_REG   = SP_REG_IDX,
    parameter logic [31:0] SP_INIT  = SP_INIT_VAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     mem_out,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic [REG_ADDR_W-1:0] reg_dst,
    input  logic                  reg_wr,
    input  logic                  wb_sel,
    input  logic                  call,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic [DATA_W-1:0]     wb_data
);

    // Index 0 has no storage; reads of it are forced to zero below.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

    wb_select #(
        .LINK_REG (LINK_REG)
    ) u_wb_select (
        .call_i     (call),
        .reg_wr_i   (reg_wr),
        .wb_sel_i   (wb_sel),
        .reg_dst_i  (reg_dst),
        .mem_out_i  (mem_out),
        .alu_out_i  (alu_out),
        .pc_plus4_i (pc_plus4),
        .wb_en_o    (wb_en),
        .wb_dst_o   (wb_dst),
        .wb_data_o  (wb_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_REG) ? SP_INIT : '0;
            end
        end else if (wb_en) begin
            regs_q[wb_dst] <= wb_data;
        end
    end

    // Bypass is suppressed while in reset so the read ports show the reset contents.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (rst_n && wb_en && (rd_addr_a == wb_dst)) begin
            rd_data_a = wb_data;
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = regs_q[rd_addr_b];
        end
        if (rst_n && wb_en && (rd_addr_b == wb_dst)) begin
            rd_data_b = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled on the low clock phase.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_out, alu_out, pc_plus4;
    logic [3:0]  reg_dst, rd_addr_a, rd_addr_b;
    logic        reg_wr, wb_sel, call;
    logic [31:0] rd_data_a, rd_data_b, wb_data;
    logic        wb_en;
    logic [3:0]  wb_dst;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [16];

    localparam logic [31:0] SP_RST = 32'h0000_FFFC;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_out   (mem_out),
        .alu_out   (alu_out),
        .pc_plus4  (pc_plus4),
        .reg_dst   (reg_dst),
        .reg_wr    (reg_wr),
        .wb_sel    (wb_sel),
        .call      (call),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wb_en     (wb_en),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic drive(input logic c, input logic rw, input logic ws, input logic [3:0] dst,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        call = c; reg_wr = rw; wb_sel = ws; reg_dst = dst;
        alu_out = alu; mem_out = mem; pc_plus4 = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = (i == 14) ? SP_RST : 32'h0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            push(model[i]);
            chk({tag, "_a"}, rd_data_a);
            push(model[15 - i]);
            chk({tag, "_b"}, rd_data_b);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;
        model_reset();

        #12;
        check_all_regs("rst0");

        // Release reset in the low phase; first write lands on the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;

        // ALU writeback to r3
        drive(1'b0, 1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 32'h0);
        #2;
        push(32'h1);          chk("alu_wb_en", {31'b0, wb_en});
        push(32'h3);          chk("alu_wb_dst", {28'b0, wb_dst});
        push(32'hDEAD_BEEF);  chk("alu_wb_data", wb_data);
        step();
        model[3] = 32'hDEAD_BEEF;
        idle();
        rd_addr_a = 4'd3;
        #2;
        push(model[3]);       chk("alu_r3", rd_data_a);

        // Memory writeback to r3
        drive(1'b0, 1'b1, 1'b1, 4'd3, 32'hCAFE_F00D, 32'h1234_5678, 32'h0);
        #2;
        push(32'h1234_5678);  chk("mem_wb_data", wb_data);
        step();
        model[3] = 32'h1234_5678;
        idle();
        #2;
        push(model[3]);       chk("mem_r3", rd_data_a);

        // Seed r5 so a call that names r5 can be shown not to touch it
        drive(1'b0, 1'b1, 1'b0, 4'd5, 32'h0000_0055, 32'h0, 32'h0);
        step();
        model[5] = 32'h0000_0055;

        // Call with reg_wr=0: link register still written
        drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h1111_1111, 32'h2222_2222, 32'h0000_0104);
        #2;
        push(32'h1);          chk("call_wb_en", {31'b0, wb_en});
        push(32'hF);          chk("call_wb_dst", {28'b0, wb_dst});
        push(32'h0000_0104);  chk("call_wb_data", wb_data);
        step();
        model[15] = 32'h0000_0104;
        idle();
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd5;
        #2;
        push(model[15]);      chk("call_r15", rd_data_a);
        push(model[5]);       chk("call_r5_kept", rd_data_b);

        // Write-through: both ports see r7's new value before the edge
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd7;
        drive(1'b0, 1'b1, 1'b0, 4'd7, 32'hA5A5_A5A5, 32'h0, 32'h0);
        #2;
        push(32'hA5A5_A5A5);  chk("byp_a", rd_data_a);
        push(32'hA5A5_A5A5);  chk("byp_b", rd_data_b);
        step();
        model[7] = 32'hA5A5_A5A5;
        idle();
        #2;
        push(model[7]);       chk("byp_stored", rd_data_a);

        // Write to r0 is dropped and not forwarded
        rd_addr_a = 4'd0;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        #2;
        push(32'h0);          chk("r0_wb_en", {31'b0, wb_en});
        push(32'h0);          chk("r0_same", rd_data_a);
        step();
        idle();
        #2;
        push(32'h0);          chk("r0_next", rd_data_a);

        // Stall: identical inputs held for three cycles
        rd_addr_a = 4'd9;
        drive(1'b0, 1'b1, 1'b0, 4'd9, 32'h0000_0099, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #2;
            push(32'h0000_0099);
            chk("stall_r9", rd_data_a);
            step();
        end
        model[9] = 32'h0000_0099;

        // Flush: enables dropped, data changed; r9 must not move
        drive(1'b0, 1'b0, 1'b0, 4'd9, 32'h7777_7777, 32'h7777_7777, 32'h0);
        #2;
        push(32'h0);          chk("flush_wb_en", {31'b0, wb_en});
        push(model[9]);       chk("flush_same", rd_data_a);
        step();
        #2;
        push(model[9]);       chk("flush_next", rd_data_a);

        // Mid-run reset with a write to SP pending: reset wins, no bypass shown
        rd_addr_a = 4'd14;
        drive(1'b0, 1'b1, 1'b0, 4'd14, 32'h0BAD_F00D, 32'h0, 32'h0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        push(32'h1);          chk("rst_wb_en_follows", {31'b0, wb_en});
        push(SP_RST);         chk("rst_sp_no_bypass", rd_data_a);
        step();
        idle();
        check_all_regs("rst1");

        // Async release mid-low-phase; the following edge takes the write
        drive(1'b0, 1'b1, 1'b0, 4'd14, 32'h0000_1234, 32'h0, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        model[14] = 32'h0000_1234;
        idle();
        rd_addr_a = 4'd14;
        rd_addr_b = 4'd3;
        #2;
        push(model[14]);      chk("post_rst_sp", rd_data_a);
        push(model[3]);       chk("post_rst_r3", rd_data_b);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
